anvil_shared_tlb: RTL and testbench

Fully-associative second-level (shared) TLB that sits directly upstream of the page-table walker. It arbitrates ITLB and DTLB misses and looks each one up in its array. Every lookup is reported to the PTW as an access with a hit flag, and hits are refilled straight back to the requesting first-level TLB. PTW update results are captured into the array with first-invalid / round-robin replacement.

---
 rtl/anvil_shared_tlb.sv | 190 +++++++++++++++++++
 tb/tb_anvil_shared_tlb.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anvil_shared_tlb.sv
// Fully-associative shared L2 TLB between the ITLB/DTLB and the page-table walker.
// Optional hit/miss performance counters are enabled by defining SHARED_TLB_PERF_CNT_EN.
module anvil_shared_tlb #(
  parameter int unsigned ENTRIES    = 8,
  parameter int unsigned VLEN       = 64,
  parameter int unsigned ASID_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  itlb_miss_i,
  input  logic                  dtlb_miss_i,
  input  logic [VLEN-1:0]       itlb_vaddr_i,
  input  logic [VLEN-1:0]       dtlb_vaddr_i,
  input  logic                  dtlb_is_store_i,
  input  logic [ASID_WIDTH-1:0] asid_i,
  output logic                  itlb_ack_o,
  output logic                  dtlb_ack_o,
  output logic                  ptw_access_o,
  output logic                  ptw_hit_o,
  output logic [VLEN-1:0]       ptw_vaddr_o,
  output logic                  ptw_itlb_req_o,
  output logic                  ptw_is_store_o,
  input  logic                  ptw_update_valid_i,
  input  logic [26:0]           ptw_update_vpn_i,
  input  logic [ASID_WIDTH-1:0] ptw_update_asid_i,
  input  logic [1:0]            ptw_update_is_page_i,
  input  logic [63:0]           ptw_update_content_i,
  input  logic                  ptw_error_i,
  output logic                  refill_valid_o,
  output logic                  refill_is_itlb_o,
  output logic [26:0]           refill_vpn_o,
  output logic [ASID_WIDTH-1:0] refill_asid_o,
  output logic [1:0]            refill_is_page_o,
  output logic [63:0]           refill_content_o,
  output logic [31:0]           perf_hit_cnt_o,
  output logic [31:0]           perf_miss_cnt_o
);
  localparam int unsigned IW = $clog2(ENTRIES);

  typedef enum logic [1:0] {IDLE, LOOKUP, WAIT_PTW} state_e;
  state_e state_q, state_d;

  logic [ENTRIES-1:0]    valid_q;
  logic [26:0]           vpn_q     [ENTRIES];
  logic [ASID_WIDTH-1:0] asid_q    [ENTRIES];
  logic [1:0]            page_q    [ENTRIES];
  logic [63:0]           content_q [ENTRIES];
  logic [IW-1:0]         rr_q;

  logic [VLEN-1:0]       req_vaddr_q;
  logic                  req_itlb_q, req_store_q;
  logic [ASID_WIDTH-1:0] req_asid_q;

  logic [26:0]        lk_vpn;
  logic [ENTRIES-1:0] match;
  logic               hit, has_inv, fill_we;
  logic [IW-1:0]      hit_idx, inv_idx, victim;

  // Superpage entries compare only the VPN levels above their page size.
  function automatic logic tag_match(input logic [26:0] a, input logic [26:0] b,
                                     input logic [1:0] pg);
    if (pg[0])      return a[26:18] == b[26:18];
    else if (pg[1]) return a[26:9] == b[26:9];
    else            return a == b;
  endfunction

  assign lk_vpn = req_vaddr_q[38:12];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    match = '0;
    for (int i = 0; i < int'(ENTRIES); i++) begin
      match[i] = valid_q[i] && (content_q[i][5] || asid_q[i] == req_asid_q) &&
                 tag_match(vpn_q[i], lk_vpn, page_q[i]);
    end
  end

  // Descending scans so the lowest matching / invalid index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    has_inv = 1'b0;
    inv_idx = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!valid_q[i]) begin
        has_inv = 1'b1;
        inv_idx = IW'(i);
      end
    end
  end

  assign victim  = has_inv ? inv_idx : rr_q;
  assign fill_we = (state_q == WAIT_PTW) && ptw_update_valid_i && !flush_i;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (itlb_miss_i || dtlb_miss_i) state_d = LOOKUP;
      LOOKUP:   state_d = hit ? IDLE : WAIT_PTW;
      WAIT_PTW: if (ptw_update_valid_i || ptw_error_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_comb begin
    itlb_ack_o       = (state_q == IDLE) && !flush_i && itlb_miss_i;
    dtlb_ack_o       = (state_q == IDLE) && !flush_i && !itlb_miss_i && dtlb_miss_i;
    ptw_access_o     = (state_q == LOOKUP) && !flush_i;
    ptw_hit_o        = ptw_access_o && hit;
    refill_valid_o   = ptw_hit_o;
    refill_is_itlb_o = ptw_hit_o && req_itlb_q;
    refill_vpn_o     = ptw_hit_o ? vpn_q[hit_idx]     : '0;
    refill_asid_o    = ptw_hit_o ? asid_q[hit_idx]    : '0;
    refill_is_page_o = ptw_hit_o ? page_q[hit_idx]    : '0;
    refill_content_o = ptw_hit_o ? content_q[hit_idx] : '0;
  end

  assign ptw_vaddr_o    = req_vaddr_q;
  assign ptw_itlb_req_o = req_itlb_q;
  assign ptw_is_store_o = req_store_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_vaddr_q <= '0;
      req_itlb_q  <= 1'b0;
      req_store_q <= 1'b0;
      req_asid_q  <= '0;
    end else if (itlb_ack_o || dtlb_ack_o) begin
      req_vaddr_q <= itlb_ack_o ? itlb_vaddr_i : dtlb_vaddr_i;
      req_itlb_q  <= itlb_ack_o;
      req_store_q <= dtlb_ack_o && dtlb_is_store_i;
      req_asid_q  <= asid_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (fill_we) begin
      valid_q[victim] <= 1'b1;
      if (!has_inv) rr_q <= rr_q + 1'b1;
    end
  end

  // NOTE: entry payload is not reset; valid_q alone decides whether an entry can match.
  always_ff @(posedge clk_i) begin
    if (fill_we) begin
      vpn_q[victim]     <= ptw_update_vpn_i;
      asid_q[victim]    <= ptw_update_asid_i;
      page_q[victim]    <= ptw_update_is_page_i;
      content_q[victim] <= ptw_update_content_i;
    end
  end

`ifdef SHARED_TLB_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (ptw_access_o) begin
      if (hit && hit_cnt_q != 32'hFFFF_FFFF)   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (!hit && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign perf_hit_cnt_o  = hit_cnt_q;
  assign perf_miss_cnt_o = miss_cnt_q;
`else
  assign perf_hit_cnt_o  = 32'd0;
  assign perf_miss_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_anvil_shared_tlb.sv
// Self-checking bench for anvil_shared_tlb: directed scenarios plus randomized traffic
// checked against an entry-list reference model of the shared TLB.
module tb_anvil_shared_tlb;
  localparam int N = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i, itlb_miss_i, dtlb_miss_i, dtlb_is_store_i;
  logic [63:0] itlb_vaddr_i, dtlb_vaddr_i;
  logic [15:0] asid_i;
  logic        itlb_ack_o, dtlb_ack_o, ptw_access_o, ptw_hit_o, ptw_itlb_req_o, ptw_is_store_o;
  logic [63:0] ptw_vaddr_o;
  logic        ptw_update_valid_i, ptw_error_i;
  logic [26:0] ptw_update_vpn_i;
  logic [15:0] ptw_update_asid_i;
  logic [1:0]  ptw_update_is_page_i;
  logic [63:0] ptw_update_content_i;
  logic        refill_valid_o, refill_is_itlb_o;
  logic [26:0] refill_vpn_o;
  logic [15:0] refill_asid_o;
  logic [1:0]  refill_is_page_o;
  logic [63:0] refill_content_o;
  logic [31:0] perf_hit_cnt_o, perf_miss_cnt_o;

  anvil_shared_tlb dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .itlb_miss_i(itlb_miss_i), .dtlb_miss_i(dtlb_miss_i),
    .itlb_vaddr_i(itlb_vaddr_i), .dtlb_vaddr_i(dtlb_vaddr_i),
    .dtlb_is_store_i(dtlb_is_store_i), .asid_i(asid_i),
    .itlb_ack_o(itlb_ack_o), .dtlb_ack_o(dtlb_ack_o),
    .ptw_access_o(ptw_access_o), .ptw_hit_o(ptw_hit_o), .ptw_vaddr_o(ptw_vaddr_o),
    .ptw_itlb_req_o(ptw_itlb_req_o), .ptw_is_store_o(ptw_is_store_o),
    .ptw_update_valid_i(ptw_update_valid_i), .ptw_update_vpn_i(ptw_update_vpn_i),
    .ptw_update_asid_i(ptw_update_asid_i), .ptw_update_is_page_i(ptw_update_is_page_i),
    .ptw_update_content_i(ptw_update_content_i), .ptw_error_i(ptw_error_i),
    .refill_valid_o(refill_valid_o), .refill_is_itlb_o(refill_is_itlb_o),
    .refill_vpn_o(refill_vpn_o), .refill_asid_o(refill_asid_o),
    .refill_is_page_o(refill_is_page_o), .refill_content_o(refill_content_o),
    .perf_hit_cnt_o(perf_hit_cnt_o), .perf_miss_cnt_o(perf_miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: a plain list of entries plus the round-robin victim pointer.
  bit          m_valid   [N];
  logic [26:0] m_vpn     [N];
  logic [15:0] m_asid    [N];
  logic [1:0]  m_page    [N];
  logic [63:0] m_content [N];
  int          m_rr = 0;
  int          m_hits = 0;
  int          m_miss = 0;

  function automatic int model_lookup(input logic [26:0] vpn, input logic [15:0] asid);
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && (m_content[i][5] || m_asid[i] == asid)) begin
        if (m_page[i][0] && vpn[26:18] == m_vpn[i][26:18]) return i;
        if (!m_page[i][0] && m_page[i][1] && vpn[26:9] == m_vpn[i][26:9]) return i;
        if (m_page[i] == 2'b00 && vpn == m_vpn[i]) return i;
      end
    end
    return -1;
  endfunction

  function automatic void model_fill(input logic [26:0] vpn, input logic [15:0] asid,
                                     input logic [1:0] pg, input logic [63:0] content);
    int idx = -1;
    for (int i = N - 1; i >= 0; i--) if (!m_valid[i]) idx = i;
    if (idx < 0) begin
      idx  = m_rr;
      m_rr = (m_rr + 1) % N;
    end
    m_valid[idx] = 1; m_vpn[idx] = vpn; m_asid[idx] = asid;
    m_page[idx] = pg; m_content[idx] = content;
  endfunction

  function automatic void model_flush();
    for (int i = 0; i < N; i++) m_valid[i] = 0;
  endfunction

  function automatic logic [63:0] mkva(input logic [26:0] vpn, input logic [11:0] off);
    return {25'd0, vpn, off};
  endfunction

  // One complete request: ack in IDLE, then the LOOKUP cycle checked against the model.
  task automatic lookup(input bit itlb, input logic [63:0] va, input bit st,
                        input logic [15:0] asid, output bit hit);
    int idx;
    asid_i = asid;
    if (itlb) begin itlb_miss_i = 1; itlb_vaddr_i = va; end
    else begin dtlb_miss_i = 1; dtlb_vaddr_i = va; dtlb_is_store_i = st; end
    #1;
    checks++;
    if (itlb_ack_o !== itlb || dtlb_ack_o !== !itlb) begin
      errors++;
      $display("FAIL ack: itlb_ack=%b dtlb_ack=%b, required itlb_ack=%b", itlb_ack_o, dtlb_ack_o, itlb);
    end
    @(negedge clk_i);
    itlb_miss_i = 0; dtlb_miss_i = 0; dtlb_is_store_i = 0;
    #1;
    idx = model_lookup(va[38:12], asid);
    hit = (idx >= 0);
    checks++;
    if (ptw_access_o !== 1'b1 || ptw_hit_o !== hit) begin
      errors++;
      $display("FAIL access: access=%b hit=%b, required access=1 hit=%b", ptw_access_o, ptw_hit_o, hit);
    end
    checks++;
    if (ptw_vaddr_o !== va || ptw_itlb_req_o !== itlb || ptw_is_store_o !== (st && !itlb)) begin
      errors++;
      $display("FAIL ptw_req: vaddr=%h itlb=%b store=%b, required %h %b %b",
               ptw_vaddr_o, ptw_itlb_req_o, ptw_is_store_o, va, itlb, st && !itlb);
    end
    checks++;
    if (hit) begin
      m_hits++;
      if (refill_valid_o !== 1'b1 || refill_is_itlb_o !== itlb || refill_vpn_o !== m_vpn[idx] ||
          refill_asid_o !== m_asid[idx] || refill_is_page_o !== m_page[idx] ||
          refill_content_o !== m_content[idx]) begin
        errors++;
        $display("FAIL refill: v=%b itlb=%b vpn=%h asid=%h pg=%b pte=%h, required entry %0d vpn=%h asid=%h pg=%b pte=%h",
                 refill_valid_o, refill_is_itlb_o, refill_vpn_o, refill_asid_o, refill_is_page_o,
                 refill_content_o, idx, m_vpn[idx], m_asid[idx], m_page[idx], m_content[idx]);
      end
    end else begin
      m_miss++;
      if (refill_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL refill_on_miss: refill_valid=%b, required 0", refill_valid_o);
      end
    end
    @(negedge clk_i);
  endtask

  // Completes a walk while in WAIT_PTW; a held DTLB miss must not be acked meanwhile.
  task automatic fill(input logic [26:0] vpn, input logic [15:0] asid, input logic [1:0] pg,
                      input logic [63:0] content, input bit with_err);
    ptw_update_valid_i = 1; ptw_error_i = with_err;
    ptw_update_vpn_i = vpn; ptw_update_asid_i = asid;
    ptw_update_is_page_i = pg; ptw_update_content_i = content;
    dtlb_miss_i = 1;
    #1;
    checks++;
    if (dtlb_ack_o !== 1'b0 || itlb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL ack_in_wait: dtlb_ack=%b itlb_ack=%b, required 0 0", dtlb_ack_o, itlb_ack_o);
    end
    @(negedge clk_i);
    ptw_update_valid_i = 0; ptw_error_i = 0; dtlb_miss_i = 0;
    model_fill(vpn, asid, pg, content);
  endtask

  task automatic walk_error();
    ptw_error_i = 1;
    @(negedge clk_i);
    ptw_error_i = 0;
  endtask

  // Looks up a 4K page and, on a miss, fills it (so it hits afterwards).
  task automatic ensure_page(input bit itlb, input logic [26:0] vpn, input logic [15:0] asid,
                             input logic [63:0] content);
    bit h;
    lookup(itlb, mkva(vpn, 12'h010), 0, asid, h);
    if (!h) fill(vpn, asid, 2'b00, content, 0);
  endtask

  task automatic test_reset();
    rst_i = 1; flush_i = 0; itlb_miss_i = 0; dtlb_miss_i = 0; dtlb_is_store_i = 0;
    itlb_vaddr_i = '0; dtlb_vaddr_i = '0; asid_i = '0;
    ptw_update_valid_i = 0; ptw_error_i = 0; ptw_update_vpn_i = '0; ptw_update_asid_i = '0;
    ptw_update_is_page_i = '0; ptw_update_content_i = '0;
    #1;
    checks++;
    if ({itlb_ack_o, dtlb_ack_o, ptw_access_o, ptw_hit_o, ptw_itlb_req_o, ptw_is_store_o,
         refill_valid_o, refill_is_itlb_o} !== 8'b0 || ptw_vaddr_o !== 64'd0 ||
        refill_vpn_o !== 27'd0 || refill_content_o !== 64'd0 ||
        perf_hit_cnt_o !== 32'd0 || perf_miss_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: access=%b refill=%b vaddr=%h hitcnt=%0d misscnt=%0d, required all 0",
               ptw_access_o, refill_valid_o, ptw_vaddr_o, perf_hit_cnt_o, perf_miss_cnt_o);
    end
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    @(negedge clk_i);
    #1;
    checks++;
    if (ptw_access_o !== 1'b0 || itlb_ack_o !== 1'b0 || dtlb_ack_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: access=%b acks=%b%b, required 0", ptw_access_o, itlb_ack_o, dtlb_ack_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_cold_miss();
    bit h;
    logic [63:0] va = 64'h0000_0040_1234_5000;
    lookup(0, va, 0, 16'd3, h);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL cold_miss: model hit=%b, required 0", h); end
    fill(va[38:12], 16'd3, 2'b00, 64'h0000_0000_1234_50cf & ~64'h20, 0);
    lookup(0, va, 0, 16'd3, h);
    checks++;
    if (h !== 1'b1 || refill_vpn_o !== 27'd0) begin
      errors++; $display("FAIL cold_refill: hit=%b, required 1", h);
    end
  endtask

  task automatic test_superpage_global();
    bit h;
    logic [26:0] vpn = 27'h12_3A05;
    lookup(1, mkva(vpn, 12'h0), 0, 16'd5, h);
    if (!h) fill(vpn, 16'd5, 2'b10, 64'h0000_0000_0ABC_00EF, 0);
    lookup(0, mkva(vpn ^ 27'h1A5, 12'h8), 1, 16'd7, h);
    checks++;
    if (h !== 1'b1) begin errors++; $display("FAIL global_2m_hit: hit=%b, required 1", h); end
    flush_i = 1; @(negedge clk_i); flush_i = 0; model_flush();
    lookup(1, mkva(vpn, 12'h0), 0, 16'd5, h);
    if (!h) fill(vpn, 16'd5, 2'b10, 64'h0000_0000_0ABC_00CF, 0);
    lookup(0, mkva(vpn ^ 27'h1A5, 12'h8), 0, 16'd7, h);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL nonglobal_2m_miss: hit=%b, required 0", h); end
    if (!h) walk_error();
  endtask

  task automatic test_back_to_back();
    bit h;
    int idx;
    logic [63:0] va1 = mkva(27'h0_1111, 12'h0);
    logic [63:0] va2 = mkva(27'h0_2222, 12'h0);
    ensure_page(1, va1[38:12], 16'd9, 64'h11C1);
    ensure_page(0, va2[38:12], 16'd9, 64'h22C1);
    itlb_miss_i = 1; itlb_vaddr_i = va1; dtlb_miss_i = 1; dtlb_vaddr_i = va2;
    dtlb_is_store_i = 1; asid_i = 16'd9;
    #1;
    checks++;
    if (itlb_ack_o !== 1'b1 || dtlb_ack_o !== 1'b0) begin
      errors++; $display("FAIL itlb_priority: itlb_ack=%b dtlb_ack=%b, required 1 0", itlb_ack_o, dtlb_ack_o);
    end
    @(negedge clk_i);
    itlb_miss_i = 0;
    #1;
    idx = model_lookup(va1[38:12], 16'd9);
    if (idx >= 0) m_hits++; else m_miss++;
    checks++;
    if (ptw_access_o !== 1'b1 || ptw_itlb_req_o !== 1'b1 || ptw_hit_o !== (idx >= 0) ||
        dtlb_ack_o !== 1'b0 || refill_is_itlb_o !== 1'b1) begin
      errors++;
      $display("FAIL itlb_lookup: access=%b itlb_req=%b hit=%b dtlb_ack=%b, required 1 1 1 0",
               ptw_access_o, ptw_itlb_req_o, ptw_hit_o, dtlb_ack_o);
    end
    @(negedge clk_i);
    #1;
    checks++;
    if (dtlb_ack_o !== 1'b1) begin
      errors++; $display("FAIL dtlb_second_ack: dtlb_ack=%b, required 1", dtlb_ack_o);
    end
    lookup(0, va2, 1, 16'd9, h);
  endtask

  task automatic test_replacement();
    bit h;
    flush_i = 1; @(negedge clk_i); flush_i = 0; model_flush();
    for (int i = 0; i < 10; i++) begin
      lookup(0, mkva(27'h40_0000 + 27'(i), 12'h0), 0, 16'd1, h);
      checks++;
      if (h !== 1'b0) begin errors++; $display("FAIL repl_fill_miss: page %0d hit=%b, required 0", i, h); end
      fill(27'h40_0000 + 27'(i), 16'd1, 2'b00, 64'h1000 + 64'(i) * 64'h10 + 64'h1, 0);
    end
    lookup(1, mkva(27'h40_0000, 12'h0), 0, 16'd1, h);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL repl_evicted: page 0 hit=%b, required 0", h); end
    walk_error();
    for (int i = 2; i < 10; i++) lookup(1, mkva(27'h40_0000 + 27'(i), 12'h0), 0, 16'd1, h);
  endtask

  task automatic test_flush();
    bit h;
    logic [26:0] pa = 27'h5_0001, pb = 27'h5_0002, pc = 27'h5_0003;
    ensure_page(0, pa, 16'd2, 64'hA1);
    ensure_page(0, pb, 16'd2, 64'hB1);
    lookup(0, mkva(pc, 12'h0), 0, 16'd2, h);
    flush_i = 1; ptw_update_valid_i = 1; ptw_update_vpn_i = pc; ptw_update_asid_i = 16'd2;
    ptw_update_is_page_i = 2'b00; ptw_update_content_i = 64'hC1;
    @(negedge clk_i);
    flush_i = 0; ptw_update_valid_i = 0; model_flush();
    lookup(0, mkva(pa, 12'h0), 0, 16'd2, h); if (!h) walk_error();
    lookup(1, mkva(pb, 12'h0), 0, 16'd2, h); if (!h) walk_error();
    lookup(0, mkva(pc, 12'h0), 0, 16'd2, h);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL flush_discards_fill: hit=%b, required 0", h); end
    fill(pc, 16'd2, 2'b00, 64'hC1, 0);
    // Flush while a miss is held in IDLE: no ack.
    dtlb_miss_i = 1; dtlb_vaddr_i = mkva(pc, 12'h0); flush_i = 1;
    #1;
    checks++;
    if (dtlb_ack_o !== 1'b0 || itlb_ack_o !== 1'b0) begin
      errors++; $display("FAIL flush_no_ack: dtlb_ack=%b, required 0", dtlb_ack_o);
    end
    @(negedge clk_i);
    flush_i = 0; dtlb_miss_i = 0; model_flush();
    ensure_page(1, pa, 16'd2, 64'hA1);
    // Flush in the LOOKUP cycle of a would-be hit.
    itlb_miss_i = 1; itlb_vaddr_i = mkva(pa, 12'h0); asid_i = 16'd2;
    @(negedge clk_i);
    itlb_miss_i = 0; flush_i = 1;
    #1;
    checks++;
    if (ptw_access_o !== 1'b0 || refill_valid_o !== 1'b0 || ptw_hit_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_lookup: access=%b refill=%b, required 0 0", ptw_access_o, refill_valid_o);
    end
    @(negedge clk_i);
    flush_i = 0; model_flush();
    lookup(1, mkva(pa, 12'h0), 0, 16'd2, h);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL flush_clears: hit=%b, required 0", h); end
    walk_error();
  endtask

  task automatic test_error();
    bit h;
    logic [26:0] pe = 27'h6_0ABC;
    lookup(0, mkva(pe, 12'h4), 1, 16'd4, h);
    walk_error();
    lookup(0, mkva(pe, 12'h4), 0, 16'd4, h);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL error_no_write: hit=%b, required 0", h); end
    walk_error();
    // Update pulse while IDLE must be ignored.
    ptw_update_valid_i = 1; ptw_update_vpn_i = pe; ptw_update_asid_i = 16'd4;
    ptw_update_is_page_i = 2'b00; ptw_update_content_i = 64'hE1;
    @(negedge clk_i);
    ptw_update_valid_i = 0;
    lookup(1, mkva(pe, 12'h4), 0, 16'd4, h);
    checks++;
    if (h !== 1'b0) begin errors++; $display("FAIL idle_update_ignored: hit=%b, required 0", h); end
    fill(pe, 16'd4, 2'b00, 64'hE1, 1);
    lookup(1, mkva(pe, 12'h4), 0, 16'd4, h);
    checks++;
    if (h !== 1'b1) begin errors++; $display("FAIL update_wins_over_error: hit=%b, required 1", h); end
  endtask

  task automatic test_random();
    bit h;
    logic [26:0] pool [12];
    for (int i = 0; i < 12; i++) pool[i] = 27'($urandom);
    for (int n = 0; n < 80; n++) begin
      logic [26:0] vpn = pool[$urandom_range(0, 11)];
      logic [15:0] asid = 16'($urandom_range(1, 2));
      if ($urandom_range(0, 15) == 0) begin
        flush_i = 1; @(negedge clk_i); flush_i = 0; model_flush();
      end
      lookup(bit'($urandom_range(0, 1)), mkva(vpn, 12'($urandom)), bit'($urandom_range(0, 1)), asid, h);
      if (!h) begin
        if ($urandom_range(0, 9) < 7) begin
          int p = $urandom_range(0, 2);
          logic [63:0] pte = {$urandom, $urandom};
          fill(vpn, asid, (p == 0) ? 2'b00 : (p == 1) ? 2'b01 : 2'b10, pte, 0);
        end else begin
          walk_error();
        end
      end
    end
  endtask

  task automatic test_perf();
    #1;
    checks++;
`ifdef SHARED_TLB_PERF_CNT_EN
    if (perf_hit_cnt_o !== 32'(m_hits) || perf_miss_cnt_o !== 32'(m_miss)) begin
      errors++;
      $display("FAIL perf_counters: hits=%0d misses=%0d, required %0d %0d",
               perf_hit_cnt_o, perf_miss_cnt_o, m_hits, m_miss);
    end
`else
    if (perf_hit_cnt_o !== 32'd0 || perf_miss_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL perf_disabled: hits=%0d misses=%0d, required 0 0", perf_hit_cnt_o, perf_miss_cnt_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_superpage_global();
    test_back_to_back();
    test_replacement();
    test_flush();
    test_error();
    test_random();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
